// File: rtl/sgd_sync_pkg.sv
// Shared definitions for the x_updated BRAM sync scheduler.
//   - scheduler state encodings (legacy localparam constants)
//   - default row width and word width
//   - calc_rows(): number of BRAM rows covering a model dimension
package sgd_sync_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BANK_WORDS_DEF = 8;
  localparam int unsigned W = BANK_WORDS_DEF * WORD_W;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StUpdate = 3'd1;
  localparam logic [2:0] StDrain  = 3'd2;
  localparam logic [2:0] StSyncRd = 3'd3;
  localparam logic [2:0] StSyncWr = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  // ceil(dim / 2^shift)
  function automatic logic [31:0] calc_rows(input logic [31:0] dim, input int unsigned shift);
    logic [31:0] mask;
    mask = (32'd1 << shift) - 32'd1;
    return (dim >> shift) + {31'd0, (dim & mask) != 32'd0};
  endfunction

endpackage

// File: rtl/sgd_sync_fifo.sv
// Tx staging FIFO for the sync path.
//   clk, rst         : clock, asynchronous active-high reset
//   flush            : synchronous empty (drops contents, pointers to 0)
//   push, push_data  : write side; push at full is accepted only together with pop
//   pop              : read side; ignored when empty
//   head             : current head entry (undefined when count == 0)
//   count            : occupancy, 0..DEPTH
module sgd_sync_fifo #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    // Full FIFO still accepts a push when the head leaves in the same cycle.
    do_push = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/sgd_x_sync_sched.sv
// Time-shares the x_updated BRAM between the gradient-update pipeline and the
// model-sync path. Per epoch: one update pass over x, drain of update writes,
// stream x to the network (tx), write averaged x back (rx).
//   clk, rst                   : clock, asynchronous active-high reset
//   started                    : job enable (level); low aborts to IDLE
//   dimension, num_epochs      : job size, sampled when leaving IDLE
//   upd_grant / upd_issue      : update pipeline row grant / row consumed
//   upd_rd_addr, upd_wr_*      : update pipeline BRAM ports
//   bram_rd_*, bram_wr_*       : BRAM ports
//   tx_* / rx_*                : network stream out / averaged stream in
//   epoch_cnt, done            : progress
//   err_stray_wr               : sticky, update write seen outside UPDATE/DRAIN
module sgd_x_sync_sched
  import sgd_sync_pkg::*;
#(
  parameter int unsigned BANK_WORDS = 8,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned ROW_SHIFT  = 6,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned RowW      = BANK_WORDS * WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              started,
  input  logic [31:0]       dimension,
  input  logic [15:0]       num_epochs,
  output logic              upd_grant,
  input  logic              upd_issue,
  input  logic [ADDR_W-1:0] upd_rd_addr,
  input  logic              upd_wr_en,
  input  logic [ADDR_W-1:0] upd_wr_addr,
  input  logic [RowW-1:0]   upd_wr_data,
  output logic [ADDR_W-1:0] bram_rd_addr,
  input  logic [RowW-1:0]   bram_rd_data,
  output logic              bram_wr_en,
  output logic [ADDR_W-1:0] bram_wr_addr,
  output logic [RowW-1:0]   bram_wr_data,
  output logic              tx_valid,
  output logic [RowW-1:0]   tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [RowW-1:0]   rx_data,
  output logic              rx_ready,
  output logic [15:0]       epoch_cnt,
  output logic              done,
  output logic              err_stray_wr
);

  localparam int unsigned CW  = ADDR_W + 1;
  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     rows_q, rows_d;
  logic [CW-1:0]     issue_cnt_q, issue_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d, tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [15:0]       num_epochs_q, num_epochs_d, epoch_cnt_q, epoch_cnt_d;
  logic              err_q, err_d;
  logic [RD_LAT-1:0] vld_q, vld_d;

  logic [31:0]       rows_calc;
  logic [CW-1:0]     issue_nxt;
  logic              in_upd, upd_phase, abort;
  logic              issue_fire, wr_fire, rd_fire, tx_fire, rx_fire;
  logic [FCW-1:0]    inflight, fifo_count;
  logic [RowW-1:0]   fifo_head;
  logic              fifo_flush, fifo_push;

  assign rows_calc = calc_rows(dimension, ROW_SHIFT);
  assign abort     = (state_q != StIdle) && !started;
  assign upd_phase = (state_q == StUpdate) || (state_q == StDrain);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(RD_LAT); i++) inflight = inflight + FCW'(vld_q[i]);
  end

  always_comb begin
    in_upd     = (state_q == StUpdate) && (issue_cnt_q < rows_q);
    issue_fire = in_upd && upd_issue;
    issue_nxt  = issue_cnt_q + CW'(issue_fire);
    // Grant falls in the same cycle as the last issue.
    upd_grant  = in_upd && (issue_nxt < rows_q);
    wr_fire    = upd_phase && upd_wr_en;
    rd_fire    = (state_q == StSyncRd) && (rd_cnt_q < rows_q) &&
                 ((inflight + fifo_count) < FCW'(FIFO_DEPTH));
    tx_valid   = (state_q == StSyncRd) && (fifo_count != '0);
    tx_fire    = tx_valid && tx_ready;
    tx_data    = tx_valid ? fifo_head : '0;
    rx_ready   = (state_q == StSyncWr);
    rx_fire    = rx_ready && rx_valid;
    fifo_push  = (state_q == StSyncRd) && vld_q[RD_LAT-1];
    fifo_flush = (state_q != StSyncRd) || abort;
    done       = (state_q == StDone);
  end

  // Read-return tracker: bit i set means a read issued i+1 cycles ago.
  always_comb begin
    vld_d = '0;
    if (!fifo_flush) begin
      vld_d[0] = rd_fire;
      for (int i = 1; i < int'(RD_LAT); i++) vld_d[i] = vld_q[i-1];
    end
  end

  always_comb begin
    state_d      = state_q;
    rows_d       = rows_q;
    num_epochs_d = num_epochs_q;
    epoch_cnt_d  = epoch_cnt_q;
    issue_cnt_d  = issue_cnt_q;
    wr_cnt_d     = upd_phase ? wr_cnt_q + CW'(wr_fire) : wr_cnt_q;
    rd_cnt_d     = rd_cnt_q + CW'(rd_fire);
    tx_cnt_d     = tx_cnt_q + CW'(tx_fire);
    rx_cnt_d     = rx_cnt_q + CW'(rx_fire);
    err_d        = err_q | (upd_wr_en && !upd_phase);
    case (state_q)
      StIdle: begin
        rd_cnt_d = '0;
        tx_cnt_d = '0;
        rx_cnt_d = '0;
        if (started) begin
          rows_d       = rows_calc[CW-1:0];
          num_epochs_d = num_epochs;
          epoch_cnt_d  = '0;
          issue_cnt_d  = '0;
          wr_cnt_d     = '0;
          state_d      = ((rows_calc == '0) || (num_epochs == '0)) ? StDone : StUpdate;
        end
      end
      StUpdate: begin
        issue_cnt_d = issue_nxt;
        if (issue_nxt == rows_q) state_d = StDrain;
      end
      StDrain: begin
        if (wr_cnt_q == rows_q) state_d = StSyncRd;
      end
      StSyncRd: begin
        if (tx_fire && (tx_cnt_q + CW'(1) == rows_q)) state_d = StSyncWr;
      end
      StSyncWr: begin
        if (rx_fire && (rx_cnt_q + CW'(1) == rows_q)) begin
          epoch_cnt_d = epoch_cnt_q + 16'd1;
          issue_cnt_d = '0;
          wr_cnt_d    = '0;
          rd_cnt_d    = '0;
          tx_cnt_d    = '0;
          rx_cnt_d    = '0;
          state_d     = (epoch_cnt_q + 16'd1 == num_epochs_q) ? StDone : StUpdate;
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d     = StIdle;
      epoch_cnt_d = '0;
      issue_cnt_d = '0;
      wr_cnt_d    = '0;
      rd_cnt_d    = '0;
      tx_cnt_d    = '0;
      rx_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rows_q       <= '0;
      num_epochs_q <= '0;
      epoch_cnt_q  <= '0;
      issue_cnt_q  <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      tx_cnt_q     <= '0;
      rx_cnt_q     <= '0;
      err_q        <= 1'b0;
      vld_q        <= '0;
    end else begin
      state_q      <= state_d;
      rows_q       <= rows_d;
      num_epochs_q <= num_epochs_d;
      epoch_cnt_q  <= epoch_cnt_d;
      issue_cnt_q  <= issue_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      err_q        <= err_d;
      vld_q        <= vld_d;
    end
  end

  // BRAM port mux, selected by registered state only.
  always_comb begin
    bram_rd_addr = '0;
    bram_wr_en   = 1'b0;
    bram_wr_addr = '0;
    bram_wr_data = '0;
    case (state_q)
      StUpdate, StDrain: begin
        bram_rd_addr = upd_rd_addr;
        bram_wr_en   = upd_wr_en;
        bram_wr_addr = upd_wr_addr;
        bram_wr_data = upd_wr_data;
      end
      StSyncRd: bram_rd_addr = rd_cnt_q[ADDR_W-1:0];
      StSyncWr: begin
        bram_wr_en   = rx_valid;
        bram_wr_addr = rx_cnt_q[ADDR_W-1:0];
        bram_wr_data = rx_data;
      end
      default: ;
    endcase
  end

  sgd_sync_fifo #(
    .WIDTH (RowW),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (bram_rd_data),
    .pop       (tx_fire),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign epoch_cnt    = epoch_cnt_q;
  assign err_stray_wr = err_q;

endmodule

// File: tb/tb_sgd_x_sync_sched.sv
module tb_sgd_x_sync_sched;
  import sgd_sync_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned BW = 64;

  logic          clk = 1'b0;
  logic          rst, started;
  logic [31:0]   dimension;
  logic [15:0]   num_epochs;
  logic          upd_grant, upd_issue, upd_wr_en;
  logic [AW-1:0] upd_rd_addr, upd_wr_addr, bram_rd_addr, bram_wr_addr;
  logic [BW-1:0] upd_wr_data, bram_rd_data, bram_wr_data, tx_data, rx_data;
  logic          bram_wr_en, tx_valid, tx_ready, rx_valid, rx_ready, done, err_stray_wr;
  logic [15:0]   epoch_cnt;

  sgd_x_sync_sched #(
    .BANK_WORDS (2),
    .ADDR_W     (AW),
    .ROW_SHIFT  (6),
    .RD_LAT     (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .started      (started),
    .dimension    (dimension),
    .num_epochs   (num_epochs),
    .upd_grant    (upd_grant),
    .upd_issue    (upd_issue),
    .upd_rd_addr  (upd_rd_addr),
    .upd_wr_en    (upd_wr_en),
    .upd_wr_addr  (upd_wr_addr),
    .upd_wr_data  (upd_wr_data),
    .bram_rd_addr (bram_rd_addr),
    .bram_rd_data (bram_rd_data),
    .bram_wr_en   (bram_wr_en),
    .bram_wr_addr (bram_wr_addr),
    .bram_wr_data (bram_wr_data),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .epoch_cnt    (epoch_cnt),
    .done         (done),
    .err_stray_wr (err_stray_wr)
  );

  always #5 clk = ~clk;

  // BRAM model with two-cycle read latency.
  logic [BW-1:0] mem [16];
  logic [BW-1:0] rd_p0, rd_p1;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (bram_wr_en) begin
      mem[bram_wr_addr[3:0]] <= bram_wr_data;
    end
    rd_p0 <= mem[bram_rd_addr[3:0]];
    rd_p1 <= rd_p0;
  end
  assign bram_rd_data = rd_p1;

  logic [BW-1:0] tx_q [$];
  int            fifo_max = 0;
  int            wr_seen  = 0;
  always @(negedge clk) begin
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (int'(dut.fifo_count) > fifo_max) fifo_max = int'(dut.fifo_count);
    if (bram_wr_en) wr_seen++;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat_upd(input int ep, input int i);
    return 64'hC0DE_0000_0000_0000 | (64'(ep) << 16) | 64'(i);
  endfunction

  function automatic logic [63:0] pat_rx(input int ep, input int i);
    return 64'hAB5A_0000_0000_0000 | (64'(ep) << 16) | 64'(i);
  endfunction

  task automatic wait_state(input logic [2:0] st, input string tag);
    int n = 0;
    while (dut.state_q !== st && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 64'(dut.state_q), 64'(st));
  endtask

  // One update pass: issue a row each cycle, write row k back `lag` cycles later.
  task automatic do_update(input int rows, input int lag, input int ep);
    for (int c = 0; c < rows + lag; c++) begin
      upd_issue   = (c < rows);
      upd_rd_addr = AW'(c);
      upd_wr_en   = (c >= lag);
      upd_wr_addr = (c >= lag) ? AW'(c - lag) : '0;
      upd_wr_data = pat_upd(ep, c - lag);
      #1;
      if (c < rows) chk("upd_grant", 64'(upd_grant), 64'(c < rows - 1));
      if (c >= lag) chk("wr_in_upd_phase",
                        64'(dut.state_q == StUpdate || dut.state_q == StDrain), 64'd1);
      if (lag > 0 && c == rows - 1 + lag) chk("drain_hold", 64'(dut.state_q), 64'(StDrain));
      tick();
    end
    upd_issue = 1'b0;
    upd_wr_en = 1'b0;
  endtask

  task automatic do_tx(input int rows, input bit toggle, input int ep);
    int n = 0;
    tx_q.delete();
    while (dut.state_q !== StSyncWr && n < 300) begin
      tx_ready = toggle ? ((n % 3) == 0) : 1'b1;
      tick();
      n++;
    end
    tx_ready = 1'b0;
    chk("reach_sync_wr", 64'(dut.state_q), 64'(StSyncWr));
    chk("tx_beats", 64'(tx_q.size()), 64'(rows));
    for (int i = 0; i < rows && i < tx_q.size(); i++) chk("tx_data", tx_q[i], pat_upd(ep, i));
  endtask

  task automatic do_rx(input int first, input int cnt, input int ep);
    for (int i = first; i < first + cnt; i++) begin
      rx_valid = 1'b1;
      rx_data  = pat_rx(ep, i);
      #1;
      chk("rx_ready", 64'(rx_ready), 64'd1);
      chk("rx_wr_addr", 64'(bram_wr_addr), 64'(i));
      tick();
    end
    rx_valid = 1'b0;
    for (int i = first; i < first + cnt; i++) chk("bram_rx_data", mem[i], pat_rx(ep, i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; started = 1'b0; dimension = '0; num_epochs = '0;
    upd_issue = 1'b0; upd_rd_addr = '0; upd_wr_en = 1'b0; upd_wr_addr = '0; upd_wr_data = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 64'(dut.state_q), 64'(StIdle));
    chk("rst_outs", {upd_grant, bram_wr_en, tx_valid, rx_ready, done, err_stray_wr}, 64'd0);
    chk("rst_epoch", 64'(epoch_cnt), 64'd0);
    chk("rst_rd_addr", 64'(bram_rd_addr), 64'd0);
    rst = 1'b0;
    tick();

    // Single epoch, 200 elements -> 4 rows, no write lag, tx always ready.
    dimension = 32'd200; num_epochs = 16'd1; started = 1'b1;
    tick();
    chk("a_update", 64'(dut.state_q), 64'(StUpdate));
    do_update(4, 0, 1);
    do_tx(4, 1'b0, 1);
    do_rx(0, 4, 1);
    chk("a_done", 64'(done), 64'd1);
    chk("a_epoch", 64'(epoch_cnt), 64'd1);
    started = 1'b0;
    tick();
    chk("a_idle", 64'(dut.state_q), 64'(StIdle));
    chk("a_done_clr", 64'(done), 64'd0);

    // Write lag of 3 cycles, tx ready one cycle in three, 193 elements -> 4 rows.
    fifo_max = 0;
    dimension = 32'd193; num_epochs = 16'd1; started = 1'b1;
    tick();
    do_update(4, 3, 2);
    chk("b_drain_after_last_wr", 64'(dut.state_q), 64'(StDrain));
    do_tx(4, 1'b1, 2);
    chk("b_fifo_max", 64'(fifo_max <= 4), 64'd1);
    do_rx(0, 4, 2);
    chk("b_done", 64'(done), 64'd1);
    started = 1'b0;
    tick();

    // Three epochs on 256 elements -> 4 rows.
    dimension = 32'd256; num_epochs = 16'd3; started = 1'b1;
    tick();
    for (int e = 0; e < 3; e++) begin
      do_update(4, 1, 10 + e);
      do_tx(4, 1'b0, 10 + e);
      do_rx(0, 4, 10 + e);
      chk("c_epoch", 64'(epoch_cnt), 64'(e + 1));
      if (e < 2) begin
        chk("c_reenter", 64'(dut.state_q), 64'(StUpdate));
        chk("c_cnt_clr", {dut.issue_cnt_q, dut.wr_cnt_q}, 64'd0);
        chk("c_not_done", 64'(done), 64'd0);
      end else begin
        chk("c_done", 64'(done), 64'd1);
      end
    end
    started = 1'b0;
    tick();

    // Abort in SYNC_RD with a full FIFO, then clean restart with 130 elements -> 3 rows.
    dimension = 32'd256; num_epochs = 16'd1; started = 1'b1;
    tick();
    do_update(4, 0, 20);
    tx_ready = 1'b0;
    wait_state(StSyncRd, "d_sync_rd");
    repeat (6) tick();
    chk("d_fifo_full", 64'(dut.fifo_count), 64'd4);
    started = 1'b0;
    tick();
    chk("d_abort_idle", 64'(dut.state_q), 64'(StIdle));
    chk("d_abort_tx", 64'(tx_valid), 64'd0);
    chk("d_abort_epoch", 64'(epoch_cnt), 64'd0);
    chk("d_abort_fifo", 64'(dut.fifo_count), 64'd0);
    dimension = 32'd130; started = 1'b1;
    tick();
    do_update(3, 2, 21);
    do_tx(3, 1'b0, 21);
    do_rx(0, 3, 21);
    chk("d_restart_done", 64'(done), 64'd1);
    chk("d_restart_epoch", 64'(epoch_cnt), 64'd1);
    started = 1'b0;
    tick();

    // Degenerate jobs go straight to DONE without touching the BRAM.
    wr_seen = 0;
    dimension = 32'd0; num_epochs = 16'd2; started = 1'b1;
    tick();
    chk("e_dim0_done", 64'(dut.state_q), 64'(StDone));
    chk("e_dim0_done_o", 64'(done), 64'd1);
    repeat (2) tick();
    chk("e_no_wr", 64'(wr_seen), 64'd0);
    started = 1'b0;
    tick();
    dimension = 32'd64; num_epochs = 16'd0; started = 1'b1;
    tick();
    chk("e_ep0_done", 64'(dut.state_q), 64'(StDone));
    started = 1'b0;
    tick();

    // Stray update write in SYNC_WR, then reset in the middle of SYNC_WR.
    dimension = 32'd256; num_epochs = 16'd2; started = 1'b1;
    tick();
    do_update(4, 0, 30);
    do_tx(4, 1'b0, 30);
    do_rx(0, 2, 30);
    upd_wr_en = 1'b1; upd_wr_addr = AW'(9); upd_wr_data = 64'hDEAD_BEEF;
    #1;
    chk("f_stray_blocked", 64'(bram_wr_en), 64'd0);
    tick();
    upd_wr_en = 1'b0;
    chk("f_err_stray", 64'(err_stray_wr), 64'd1);
    chk("f_stray_mem", mem[9], 64'd0);
    chk("f_still_wr", 64'(dut.state_q), 64'(StSyncWr));
    rx_valid = 1'b1; rx_data = pat_rx(30, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("g_rst_ctl", {upd_grant, bram_wr_en, tx_valid, rx_ready, done, err_stray_wr}, 64'd0);
    chk("g_rst_epoch", 64'(epoch_cnt), 64'd0);
    chk("g_rst_wr_addr", 64'(bram_wr_addr), 64'd0);
    chk("g_rst_wr_data", bram_wr_data, 64'd0);
    chk("g_rst_tx_data", tx_data, 64'd0);
    rx_valid = 1'b0; started = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sgd_x_sync_sched.md
Name: sgd_x_sync_sched

Overview:
- Scheduler that time-shares the x_updated BRAM between the local gradient-update pipeline and the distributed model-sync path.
- Each epoch:
  - grants the BRAM to the update pipeline for exactly one pass over x;
  - blocks new issue and drains in-flight writes;
  - streams x out to the network (tx);
  - writes the averaged x back from the network (rx).
- Repeats for num_epochs. Sits between the x_updated read/write engine, the x_updated BRAM and the allreduce network interface.

Parameters:
- BANK_WORDS, 8, 32-bit words per BRAM row (row width W = BANK_WORDS*32).
- ADDR_W, 10, BRAM row address width.
- ROW_SHIFT, 6, log2(x elements per row across all engines); rows = ceil(dimension / 2^ROW_SHIFT).
- RD_LAT, 1, BRAM read latency in cycles.
- FIFO_DEPTH, 4, tx staging FIFO depth (power of two, >= RD_LAT+2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- started  in  1  job enable; level-sensitive
- dimension  in  32  model dimension; sampled in IDLE
- num_epochs  in  16  epoch count; sampled in IDLE
- upd_grant  out  1  update pipeline may issue rows (gates acc_gradient_valid upstream)
- upd_issue  in  1  update pipeline consumed one row (rd address advance)
- upd_rd_addr  in  ADDR_W  update pipeline read address
- upd_wr_en / upd_wr_addr / upd_wr_data  in  1 / ADDR_W / W  update pipeline write port
- bram_rd_addr  out  ADDR_W  to BRAM read port
- bram_rd_data  in  W  from BRAM read port
- bram_wr_en / bram_wr_addr / bram_wr_data  out  1 / ADDR_W / W  to BRAM write port
- tx_valid / tx_data / tx_ready  out / out / in  1 / W / 1  x stream to network
- rx_valid / rx_data / rx_ready  in / in / out  1 / W / 1  averaged x from network
- epoch_cnt  out  16  completed epochs
- done  out  1  all epochs complete
- err_stray_wr  out  1  sticky: upd_wr_en seen outside UPDATE/DRAIN

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all counters 0.
  - All outputs 0, except bram_rd_addr/bram_wr_addr/data, which are 0 as well.
  - FIFO emptied.
- Row count:
  - rows = dimension[31:ROW_SHIFT] + (dimension[ROW_SHIFT-1:0]!=0).
  - Registered on the IDLE->exit transition.
- FSM states: IDLE, UPDATE, DRAIN, SYNC_RD, SYNC_WR, DONE.
  - IDLE: started=1 and (rows==0 or num_epochs==0) -> DONE; started=1 otherwise -> UPDATE.
  - UPDATE:
    - upd_grant=1 while issue_cnt<rows.
    - issue_cnt increments on upd_issue.
    - When issue_cnt reaches rows, upd_grant drops in the same cycle (combinational compare on the next count) -> DRAIN.
  - DRAIN: wait until wr_cnt==rows. wr_cnt counts upd_wr_en in both UPDATE and DRAIN. Then -> SYNC_RD.
  - SYNC_RD:
    - Issues reads at addresses 0..rows-1.
    - Issues a read when inflight+fifo_count < FIFO_DEPTH.
    - Read data enters the FIFO RD_LAT cycles later; tx presents the FIFO head.
    - -> SYNC_WR when all rows have been accepted by tx (tx_valid&tx_ready count == rows).
  - SYNC_WR:
    - rx_ready=1.
    - Each rx_valid writes rx_data to address 0..rows-1 in order.
    - After the rows-th write: epoch_cnt+1.
    - If epoch_cnt+1 == num_epochs -> DONE; else -> UPDATE with issue_cnt/wr_cnt cleared.
  - DONE: done=1; started=0 -> IDLE.
- Abort: started=0 in any state except IDLE -> IDLE next cycle.
  - FIFO flushed; in-flight read returns discarded; counters and epoch_cnt cleared.
  - Writes already presented that cycle still complete.
- BRAM mux (combinational on registered state):
  - UPDATE/DRAIN: rd=upd_rd_addr, wr=upd_wr_*.
  - SYNC_RD: rd=sync address, bram_wr_en=0.
  - SYNC_WR: wr=rx path.
  - Other states: bram_wr_en=0.
- Stray writes: upd_wr_en outside UPDATE/DRAIN is dropped and sets err_stray_wr (cleared only by rst).
- Address arithmetic: all address counters wrap modulo 2^ADDR_W; rows > 2^ADDR_W is illegal and not checked.
- FIFO interaction: simultaneous push and pop at full is legal, and occupancy is unchanged.

Decomposition:
- Package sgd_sync_pkg:
  - state enum;
  - row-count function;
  - W constant.
- One sub-module: sgd_sync_fifo (W-wide, FIFO_DEPTH entries, push/pop/count, flush). Used for tx staging.

Test Plan:
- dimension=200, ROW_SHIFT=6 (rows=4), num_epochs=1, tx_ready=1, rx 4 beats:
  - upd_grant high for exactly 4 upd_issue;
  - tx emits rows 0..3 in order;
  - BRAM receives rx data at 0..3;
  - done=1, epoch_cnt=1.
- UPDATE with 3-cycle write lag:
  - upd_grant drops on the 4th issue;
  - state stays DRAIN until the 4th upd_wr_en;
  - no read of address 0 before then.
- tx_ready toggling 1-of-3 cycles with RD_LAT=2:
  - no FIFO overflow;
  - tx_data sequence exactly rows 0..3;
  - fifo_count never exceeds 4.
- num_epochs=3:
  - epoch_cnt steps 1,2,3;
  - UPDATE re-entered twice with counters 0;
  - done only after the third SYNC_WR.
- started dropped mid SYNC_RD:
  - next cycle IDLE, tx_valid=0, epoch_cnt=0;
  - restart runs a full clean epoch.
- Edge/reset cases:
  - dimension=0 -> DONE directly from IDLE, with no BRAM access;
  - upd_wr_en pulsed in SYNC_WR -> err_stray_wr=1 and no BRAM write from the upd port;
  - rst asserted mid-SYNC_WR -> all outputs 0 asynchronously.
